stream_demux: RTL

- 1-to-2 registered stream demultiplexer; the inverse of the team's 2:1 byte mux (a_i/b_i/sel_i -> y_o).
- Steers each input beat to channel A or channel B according to sel_i.
- Each output channel has its own small FIFO, so one stalled consumer does not block beats steered to the other.
- Sits between a single producer and two independent consumers, e.g. splitting one byte stream into two processing lanes.

---
 rtl/stream_demux.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/stream_demux.sv
// 1-to-2 registered stream demultiplexer with a small FIFO per output channel.
// Optional STREAM_DEMUX_CNT_EN adds per-channel 16-bit pop counters.

module stream_demux_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             pop_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop;

  assign pop = valid_q & ready_i;

  // Head register is loaded from the post-edge memory image so the output never
  // depends combinationally on data_i and holds its last value when empty.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (push_i) wptr_d = wptr_q + PW'(1);
    if (pop)    rptr_d = rptr_q + PW'(1);
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != '0);
    if (valid_d) begin
      head_d = (push_i && (wptr_q == rptr_d)) ? data_i : mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  // Storage needs no reset: occupancy decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign pop_o   = pop;
endmodule

module stream_demux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             sel_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] a_o,
  output logic             a_valid_o,
  input  logic             a_ready_i,
  output logic [WIDTH-1:0] b_o,
  output logic             b_valid_o,
  input  logic             b_ready_i
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [15:0]      cnt_a_o,
  output logic [15:0]      cnt_b_o
`endif
);
  logic full_a, full_b;
  logic push_a, push_b;
  logic pop_a, pop_b;
  logic accept;

  // No full-bypass: a pop in the same cycle does not reopen a full channel.
  assign ready_o = sel_i ? !full_b : !full_a;
  assign accept  = valid_i & ready_o;
  assign push_a  = accept & ~sel_i;
  assign push_b  = accept & sel_i;

  stream_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_a),
    .data_i  (data_i),
    .ready_i (a_ready_i),
    .full_o  (full_a),
    .valid_o (a_valid_o),
    .data_o  (a_o),
    .pop_o   (pop_a)
  );

  stream_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_b),
    .data_i  (data_i),
    .ready_i (b_ready_i),
    .full_o  (full_b),
    .valid_o (b_valid_o),
    .data_o  (b_o),
    .pop_o   (pop_b)
  );

`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (pop_a) cnt_a_q <= cnt_a_q + 16'd1;
      if (pop_b) cnt_b_q <= cnt_b_q + 16'd1;
    end
  end

  assign cnt_a_o = cnt_a_q;
  assign cnt_b_o = cnt_b_q;
`else
  logic unused_pops;
  assign unused_pops = pop_a ^ pop_b;
`endif
endmodule
